// File: rtl/text_frame_buffer.sv
// text_frame_buffer: streaming character frame buffer with cursor, CR/LF/BS handling, self-clear and registered reads; define SCROLL_EN to scroll on last-row advance
module text_frame_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS = 4,
  parameter int COLS = 32,
  parameter logic [7:0] CLEAR_VAL = 8'h20
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    clr_req,
  output logic                    busy,
  input  logic [$clog2(ROWS)-1:0] r_row,
  input  logic [$clog2(COLS)-1:0] r_col,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic [$clog2(ROWS)-1:0] cur_row,
  output logic [$clog2(COLS)-1:0] cur_col
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int AW = $clog2(ROWS * COLS);
  localparam logic [DATA_WIDTH-1:0] CV = DATA_WIDTH'(CLEAR_VAL);
  typedef enum logic [1:0] {CLEAR, IDLE, ROWCLR} state_t;
  state_t state;
  logic [AW-1:0] idx, wr_addr;
  logic [RW-1:0] top, clr_row;
  logic [DATA_WIDTH-1:0] mem [ROWS*COLS];
  logic [DATA_WIDTH-1:0] wr_data;
  logic take, is_cr, is_lf, is_bs, is_chr, adv, wr_en;

  function automatic logic [RW-1:0] phys(input logic [RW-1:0] t, input logic [RW-1:0] r);
    logic [RW:0] s;
    s = {1'b0, t} + {1'b0, r};
    return (int'(s) >= ROWS) ? RW'(int'(s) - ROWS) : RW'(s);
  endfunction

  function automatic logic [AW-1:0] addr(input logic [RW-1:0] r, input logic [CW-1:0] c);
    return AW'(int'(r) * COLS + int'(c));
  endfunction

  assign in_ready = (state == IDLE) & ~clr_req;
  assign busy = (state != IDLE);
  assign take = in_valid & in_ready;
  assign is_cr = (in_data == DATA_WIDTH'(8'h0D));
  assign is_lf = (in_data == DATA_WIDTH'(8'h0A));
  assign is_bs = (in_data == DATA_WIDTH'(8'h08));
  assign is_chr = ~(is_cr | is_lf | is_bs);
  assign adv = take & (is_lf | (is_chr & (cur_col == CW'(COLS - 1))));

  // Write port: clear sweeps, backspace blanking and character stores
  always_comb begin
    wr_en = reset & ((state != IDLE) | (take & is_chr) | (take & is_bs & (cur_col != '0)));
    wr_addr = (state == CLEAR) ? idx :
              (state == ROWCLR) ? addr(clr_row, CW'(idx)) :
              addr(phys(top, cur_row), is_bs ? cur_col - CW'(1) : cur_col);
    wr_data = (state == IDLE && is_chr) ? in_data : CV;
  end

  // Storage array; a same-cycle read sees the pre-write contents
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;

  // Registered read through the logical-to-physical row mapping
  always_ff @(posedge clk)
    if (!reset) dout <= '0;
    else dout <= (int'(r_row) >= ROWS || int'(r_col) >= COLS) ? CV : mem[addr(phys(top, r_row), r_col)];

  // Sweep sequencing, clear requests and cursor movement
  always_ff @(posedge clk)
    if (!reset) begin
      state <= CLEAR; idx <= '0; top <= '0; clr_row <= '0; cur_row <= '0; cur_col <= '0;
    end else if (state != IDLE) begin
      idx <= idx + AW'(1);
      if (idx == ((state == CLEAR) ? AW'(ROWS * COLS - 1) : AW'(COLS - 1))) begin
        state <= IDLE;
        idx <= '0;
      end
    end else if (clr_req) begin
      state <= CLEAR; idx <= '0; top <= '0; cur_row <= '0; cur_col <= '0;
    end else if (take) begin
      if (is_cr | is_lf) cur_col <= '0;
      else if (is_bs) cur_col <= (cur_col != '0) ? cur_col - CW'(1) : cur_col;
      else cur_col <= (cur_col == CW'(COLS - 1)) ? '0 : cur_col + CW'(1);
      if (adv) begin
        if (cur_row != RW'(ROWS - 1)) cur_row <= cur_row + RW'(1);
        else begin
`ifdef SCROLL_EN
          top <= (top == RW'(ROWS - 1)) ? '0 : top + RW'(1);
          clr_row <= top;
          state <= ROWCLR;
`else
          cur_row <= '0;
`endif
        end
      end
    end
endmodule
